// File: rtl/axi4_burst_ram.sv
`default_nettype none
// ==========================================================================
// axi4_burst_ram : AXI4 slave RAM, FIXED/INCR/WRAP bursts, strobes, decode
// Rev 1.0
// ==========================================================================
module axi4_burst_ram #(
  parameter int                 DATA_W    = 128,
  parameter int                 ADDR_W    = 40,
  parameter int                 ID_W      = 16,
  parameter int                 MEM_AW    = 10,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 40'h00_B000_0000
) (
  input  logic                  pl_clk0,
  input  logic                  pl_aresetn,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awlock,
  input  logic [3:0]            awcache,
  input  logic [2:0]            awprot,
  input  logic [3:0]            awqos,
  input  logic [15:0]           awuser,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arlock,
  input  logic [3:0]            arcache,
  input  logic [2:0]            arprot,
  input  logic [3:0]            arqos,
  input  logic [15:0]           aruser,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int          STRB_W      = DATA_W / 8;
  localparam int          OFF_W       = $clog2(STRB_W);
  localparam int          LW          = MEM_AW + OFF_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  // Only the in-window offset is tracked, so beat addresses wrap modulo the window.
  function automatic logic [LW-1:0] next_off(input logic [LW-1:0] off, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst);
    logic [LW-1:0] step, base, wmask;
    step  = LW'(1) << size;
    base  = (off & ~(step - LW'(1))) + step;
    wmask = ((LW'(len) + LW'(1)) << size) - LW'(1);
    case (burst)
      2'b01:   next_off = base;
      2'b10:   next_off = (off & ~wmask) | (base & wmask);
      default: next_off = off;
    endcase
  endfunction

  function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
    bad_burst = (burst == 2'b11) || ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  logic [DATA_W-1:0] mem [2**MEM_AW];

  // ---------------- write path ----------------
  wstate_t           wst_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q, wburst_q;
  logic [7:0]        wlen_q, wcnt_q;
  logic [2:0]        wsize_q;
  logic [LW-1:0]     woff_q, woff_d;
  logic              wwin_q, wbad_q, wdec_q, wslv_q;
  logic              wbeat_dec, wbeat_slv, wr_hs, wr_en;

  always_comb begin
    woff_d    = next_off(woff_q, wsize_q, wlen_q, wburst_q);
    wr_hs     = (wst_q == W_DATA) && wvalid && wready_q;
    wr_en     = wr_hs && wwin_q && !wbad_q;
    wbeat_dec = wdec_q || !wwin_q;
    wbeat_slv = wslv_q || wbad_q || (wlast != (wcnt_q == wlen_q));
  end

  always_ff @(posedge pl_clk0 or negedge pl_aresetn) begin
    if (!pl_aresetn) begin
      wst_q     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      woff_q    <= '0;
      wwin_q    <= 1'b0;
      wbad_q    <= 1'b0;
      wdec_q    <= 1'b0;
      wslv_q    <= 1'b0;
    end else begin
      case (wst_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wst_q     <= W_DATA;
            bid_q     <= awid;
            wlen_q    <= awlen;
            wsize_q   <= awsize;
            wburst_q  <= awburst;
            woff_q    <= awaddr[LW-1:0];
            wwin_q    <= (awaddr[ADDR_W-1:LW] == BASE_ADDR[ADDR_W-1:LW]);
            wbad_q    <= bad_burst(awburst, awlen);
            wcnt_q    <= '0;
            wdec_q    <= 1'b0;
            wslv_q    <= 1'b0;
          end
        end
        W_DATA: begin
          if (wr_hs) begin
            woff_q <= woff_d;
            wcnt_q <= wcnt_q + 8'd1;
            wdec_q <= wbeat_dec;
            wslv_q <= wbeat_slv;
            // The beat counter, not wlast, ends the burst.
            if (wcnt_q == wlen_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              wst_q    <= W_RESP;
              bresp_q  <= wbeat_dec ? RESP_DECERR : (wbeat_slv ? RESP_SLVERR : RESP_OKAY);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wst_q     <= W_IDLE;
          end
        end
        default: wst_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge pl_clk0) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[woff_q[LW-1:OFF_W]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t           rst_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q, rburst_q;
  logic [7:0]        rlen_q, rcnt_q;
  logic [2:0]        rsize_q;
  logic [LW-1:0]     roff_q, roff_d;
  logic              rwin_q, rbad_q, rd_en, rd_ok;

  // The output register doubles as the prefetch stage: it reloads only when empty or consumed.
  always_comb begin
    roff_d = next_off(roff_q, rsize_q, rlen_q, rburst_q);
    rd_en  = (rst_q == R_FETCH) || ((rst_q == R_DATA) && rvalid_q && rready && !rlast_q);
    rd_ok  = rwin_q && !rbad_q;
  end

  always_ff @(posedge pl_clk0 or negedge pl_aresetn) begin
    if (!pl_aresetn) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_ok ? mem[roff_q[LW-1:OFF_W]] : '0;
    end
  end

  always_ff @(posedge pl_clk0 or negedge pl_aresetn) begin
    if (!pl_aresetn) begin
      rst_q     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      roff_q    <= '0;
      rwin_q    <= 1'b0;
      rbad_q    <= 1'b0;
    end else begin
      if (rd_en) begin
        roff_q  <= roff_d;
        rcnt_q  <= rcnt_q + 8'd1;
        rlast_q <= (rcnt_q == rlen_q);
        rresp_q <= !rwin_q ? RESP_DECERR : (rbad_q ? RESP_SLVERR : RESP_OKAY);
      end
      case (rst_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            rst_q     <= R_FETCH;
            rid_q     <= arid;
            rlen_q    <= arlen;
            rsize_q   <= arsize;
            rburst_q  <= arburst;
            roff_q    <= araddr[LW-1:0];
            rwin_q    <= (araddr[ADDR_W-1:LW] == BASE_ADDR[ADDR_W-1:LW]);
            rbad_q    <= bad_burst(arburst, arlen);
            rcnt_q    <= '0;
          end
        end
        R_FETCH: begin
          rvalid_q <= 1'b1;
          rst_q    <= R_DATA;
        end
        R_DATA: begin
          if (rready && rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            rst_q     <= R_IDLE;
          end
        end
        default: rst_q <= R_IDLE;
      endcase
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{awlock, awcache, awprot, awqos, awuser,
                             arlock, arcache, arprot, arqos, aruser};

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_ram.sv
`default_nettype none
// tb_axi4_burst_ram : scoreboard bench with a byte-array reference model.
module tb_axi4_burst_ram;
  localparam int          LW   = 14;
  localparam logic [39:0] BASE = 40'h00_B000_0000;

  logic         pl_clk0 = 1'b0;
  logic         pl_aresetn = 1'b0;
  logic [15:0]  awid, arid, bid, rid;
  logic [39:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;

  always #5 pl_clk0 = ~pl_clk0;

  axi4_burst_ram dut (
    .pl_clk0(pl_clk0), .pl_aresetn(pl_aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(1'b0), .awcache(4'h3), .awprot(3'h0), .awqos(4'h0), .awuser(16'h0),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(1'b0), .arcache(4'h3), .arprot(3'h0), .arqos(4'h0), .aruser(16'h0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem_m [16384];

  function automatic bit in_win(input logic [39:0] a);
    return a[39:LW] == BASE[39:LW];
  endfunction

  function automatic bit is_bad(input logic [1:0] burst, input int len);
    return (burst == 2'b11) || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Byte offset (within the window) of beat n, straight from the AXI address equations.
  function automatic int beat_off(input logic [39:0] start, input int n, input int size,
                                  input int len, input logic [1:0] burst);
    longint s, nb, total, aligned, lowb, a;
    s = longint'(start[LW-1:0]);
    nb = longint'(1) << size;
    total = nb * (len + 1);
    aligned = (s / nb) * nb;
    if (burst == 2'b00 || n == 0) a = s;
    else begin
      a = aligned + n * nb;
      if (burst == 2'b10) begin
        lowb = (s / total) * total;
        if (a >= lowb + total) a = a - total;
      end
    end
    return int'(a % 16384);
  endfunction

  typedef struct { logic [15:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [15:0] id; logic [127:0] data; logic [1:0] resp; logic last; } r_exp_t;
  b_exp_t b_q [$];
  r_exp_t r_q [$];

  logic [127:0] wd [256];
  logic [15:0]  ws [256];
  bit           wl [256];
  bit           wgap = 0;

  task automatic fill_w(input int len, input bit rand_strb);
    for (int n = 0; n <= len; n++) begin
      wd[n] = {$urandom(), $urandom(), $urandom(), $urandom()};
      ws[n] = rand_strb ? 16'($urandom()) : 16'hFFFF;
      wl[n] = (n == len);
    end
  endtask

  task automatic model_write_beat(input logic [39:0] addr, input int n, input int size,
                                  input int len, input logic [1:0] burst);
    int w;
    w = (beat_off(addr, n, size, len, burst) / 16) * 16;
    for (int b = 0; b < 16; b++)
      if (ws[n][b]) mem_m[w + b] = wd[n][b*8 +: 8];
  endtask

  task automatic wait_ready(input string name, ref logic sig);
    int t;
    t = 0;
    do begin @(negedge pl_clk0); t++; end while (!sig && t < 200);
    if (!sig) chk(name, sig, 1'b1);
    @(posedge pl_clk0); #1;
  endtask

  task automatic do_write(input logic [15:0] id, input logic [39:0] addr, input int len,
                          input int size, input logic [1:0] burst);
    bit bad, win, slv;
    int t;
    bad = is_bad(burst, len);
    win = in_win(addr);
    slv = bad;
    for (int n = 0; n <= len; n++) begin
      if (wl[n] != (n == len)) slv = 1;
      if (win && !bad) model_write_beat(addr, n, size, len, burst);
    end
    b_q.push_back('{id, !win ? 2'b11 : (slv ? 2'b10 : 2'b00)});
    @(posedge pl_clk0); #1;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1;
    wait_ready("aw_timeout", awready);
    awvalid = 0;
    for (int n = 0; n <= len; n++) begin
      if (wgap) repeat ($urandom_range(0, 2)) begin wvalid = 0; @(posedge pl_clk0); #1; end
      wvalid = 1; wdata = wd[n]; wstrb = ws[n]; wlast = wl[n];
      wait_ready("w_timeout", wready);
    end
    wvalid = 0; wlast = 0;
    t = 0;
    while (b_q.size() != 0 && t < 300) begin @(negedge pl_clk0); t++; end
    chk("b_done", 128'(b_q.size()), 128'd0);
    b_q.delete();
  endtask

  task automatic do_read(input logic [15:0] id, input logic [39:0] addr, input int len,
                         input int size, input logic [1:0] burst);
    bit bad, win;
    int t, w;
    logic [127:0] d;
    bad = is_bad(burst, len);
    win = in_win(addr);
    for (int n = 0; n <= len; n++) begin
      d = '0;
      if (win && !bad) begin
        w = (beat_off(addr, n, size, len, burst) / 16) * 16;
        for (int b = 0; b < 16; b++) d[b*8 +: 8] = mem_m[w + b];
      end
      r_q.push_back('{id, d, !win ? 2'b11 : (bad ? 2'b10 : 2'b00), n == len});
    end
    @(posedge pl_clk0); #1;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst; arvalid = 1;
    wait_ready("ar_timeout", arready);
    arvalid = 0;
    @(negedge pl_clk0); chk("r_latency_t1", rvalid, 1'b0);
    @(negedge pl_clk0); chk("r_latency_t2", rvalid, 1'b1);
    t = 0;
    while (r_q.size() != 0 && t < 600) begin @(negedge pl_clk0); t++; end
    chk("r_done", 128'(r_q.size()), 128'd0);
    r_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, awready, 1'b0);
    chk({tag, "_arready"}, arready, 1'b0);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_bid_bresp"}, {bid, bresp}, 18'h0);
    chk({tag, "_rid_rresp"}, {rid, rresp}, 18'h0);
    chk({tag, "_rdata"}, rdata, 128'h0);
  endtask

  // ---------------- ready generators ----------------
  int rmode = 0, bmode = 0, cyc = 0, bstall_n = 0;
  bit rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge pl_clk0) begin
    #1;
    cyc++;
    case (rmode)
      0:       rready = 1'b1;
      1:       rready = 1'($urandom_range(0, 1));
      default: rready = rpat[cyc % 4];
    endcase
    case (bmode)
      0: bready = 1'b1;
      1: bready = 1'($urandom_range(0, 1));
      default: begin
        if (bvalid && bstall_n < 5) begin bready = 1'b0; bstall_n++; end
        else bready = 1'b1;
      end
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  bit           pb_stall = 0, pr_stall = 0;
  logic [15:0]  pb_id, pr_id;
  logic [1:0]   pb_resp, pr_resp;
  logic [127:0] pr_data;
  logic         pr_last;

  always @(negedge pl_clk0) begin
    if (!pl_aresetn) begin
      pb_stall = 0;
      pr_stall = 0;
    end else begin
      if (pb_stall) begin
        chk("b_hold_valid", bvalid, 1'b1);
        chk("b_hold_id_resp", {bid, bresp}, {pb_id, pb_resp});
      end
      if (bvalid && bready) begin
        chk("b_expected", 128'(b_q.size()), 128'd1);
        if (b_q.size() > 0) begin
          b_exp_t e;
          e = b_q.pop_front();
          chk("bid", bid, e.id);
          chk("bresp", bresp, e.resp);
        end
      end
      pb_stall = bvalid && !bready;
      pb_id = bid; pb_resp = bresp;

      if (pr_stall) begin
        chk("r_hold_valid", rvalid, 1'b1);
        chk("r_hold_ctl", {rid, rresp, rlast}, {pr_id, pr_resp, pr_last});
        chk("r_hold_data", rdata, pr_data);
      end
      if (rvalid && rready) begin
        chk("r_expected", r_q.size() > 0, 1'b1);
        if (r_q.size() > 0) begin
          r_exp_t e;
          e = r_q.pop_front();
          chk("rid", rid, e.id);
          chk("rdata", rdata, e.data);
          chk("rresp", rresp, e.resp);
          chk("rlast", rlast, e.last);
        end
      end
      pr_stall = rvalid && !rready;
      pr_id = rid; pr_resp = rresp; pr_last = rlast; pr_data = rdata;
    end
  end

  task automatic rand_txn();
    int len, size, off, c;
    logic [1:0] burst;
    logic [39:0] addr;
    logic [15:0] id;
    id = 16'($urandom());
    burst = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 19) == 0) burst = 2'b11;
    size = $urandom_range(0, 4);
    if (burst == 2'b10) begin
      c = $urandom_range(0, 4);
      len = (c == 4) ? $urandom_range(0, 15) : (2 << c) - 1;
    end else len = $urandom_range(0, 15);
    off = $urandom_range(0, 767);
    if (burst == 2'b10) off = off & ~((1 << size) - 1);
    addr = BASE + 40'(off);
    if ($urandom_range(0, 9) == 0) addr = addr ^ (40'h1 << $urandom_range(LW, 39));
    if ($urandom_range(0, 1) == 1) begin
      fill_w(len, 1);
      do_write(id, addr, len, size, burst);
    end else begin
      do_read(id, addr, len, size, burst);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] a;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;
    rready = 1; bready = 1;

    repeat (3) @(posedge pl_clk0);
    #1 chk_all_zero("reset");
    @(negedge pl_clk0) pl_aresetn = 1;
    #1 chk("awready_before_edge", awready, 1'b0);
    @(posedge pl_clk0); #1;
    chk("awready_after_reset", awready, 1'b1);
    chk("arready_after_reset", arready, 1'b1);

    for (int k = 0; k < 4; k++) begin
      fill_w(15, 0);
      do_write(16'h0010 + 16'(k), BASE + 40'(k * 256), 15, 4, 2'b01);
    end

    fill_w(3, 0);
    for (int n = 0; n < 4; n++) wd[n] = 128'(n + 1);
    do_write(16'hA5C3, BASE, 3, 4, 2'b01);
    do_read(16'hA5C3, BASE, 3, 4, 2'b01);

    do_read(16'h0101, BASE + 40'h20, 3, 4, 2'b10);
    do_read(16'h0102, BASE + 40'h20, 2, 4, 2'b10);

    fill_w(3, 0);
    for (int n = 0; n < 4; n++) ws[n] = 16'h1 << (5 + n);
    do_write(16'h0007, BASE + 40'h5, 3, 0, 2'b01);
    do_read(16'h0007, BASE, 0, 4, 2'b01);

    rmode = 2;
    do_read(16'h0009, BASE + 40'h100, 7, 4, 2'b01);
    rmode = 0;
    bmode = 2; bstall_n = 0;
    fill_w(0, 0);
    do_write(16'hBEEF, BASE + 40'h40, 0, 4, 2'b01);
    bmode = 0;

    fill_w(1, 0);
    do_write(16'h0003, 40'h00_A000_0000, 1, 4, 2'b01);
    do_read(16'h0003, 40'h00_A000_0000, 1, 4, 2'b01);
    fill_w(3, 0); wl[1] = 1;
    do_write(16'h0004, BASE + 40'h80, 3, 4, 2'b01);
    fill_w(3, 0); wl[3] = 0;
    do_write(16'h0005, BASE + 40'hC0, 3, 4, 2'b01);
    fill_w(2, 0);
    do_write(16'h0006, BASE + 40'h20, 2, 4, 2'b10);
    fill_w(1, 0);
    do_write(16'h0016, BASE, 1, 4, 2'b11);
    do_read(16'h0008, BASE, 15, 4, 2'b01);

    rmode = 1; bmode = 1; wgap = 1;
    for (int it = 0; it < 60; it++) rand_txn();
    rmode = 0; bmode = 0; wgap = 0;

    // Reset lands while beat 2 of an 8-beat write is on the bus; beats 0 and 1 persist.
    a = BASE + 40'h200;
    fill_w(7, 0);
    model_write_beat(a, 0, 4, 7, 2'b01);
    model_write_beat(a, 1, 4, 7, 2'b01);
    @(posedge pl_clk0); #1;
    awid = 16'h0777; awaddr = a; awlen = 8'd7; awsize = 3'd4; awburst = 2'b01; awvalid = 1;
    wait_ready("aw_timeout", awready);
    awvalid = 0;
    for (int n = 0; n < 2; n++) begin
      wvalid = 1; wdata = wd[n]; wstrb = ws[n]; wlast = wl[n];
      wait_ready("w_timeout", wready);
    end
    wvalid = 1; wdata = wd[2]; wstrb = ws[2]; wlast = wl[2];
    #2 pl_aresetn = 0;
    #1 chk_all_zero("midburst");
    wvalid = 0; wlast = 0;
    repeat (2) @(posedge pl_clk0);
    @(negedge pl_clk0) pl_aresetn = 1;
    #1 chk("awready_before_edge2", awready, 1'b0);
    @(posedge pl_clk0); #1;
    chk("awready_after_reset2", awready, 1'b1);
    chk("arready_after_reset2", arready, 1'b1);
    do_read(16'h0778, a, 7, 4, 2'b01);
    fill_w(3, 0);
    do_write(16'h0779, a + 40'h10, 3, 4, 2'b01);
    do_read(16'h077A, a, 7, 4, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
